// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// state codes, opcodes, ALU operation codes, mux select encodings and the
// control-word bundle passed from the decoder to the top level.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_IMM_EXEC  = 4'd8,
        S_IMM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b111;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control word: write enables first, then mux selects.
    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
            default:                      known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational state + opcode to control-word decoder.
// Only FETCH looks at mem_ready (IRWrite/PCWrite follow it there).
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Moore decode: every field defaults to 0, each state sets what it needs.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_IMM_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                case (op_i)
                    OP_ORI:  ctrl_o.alu_op = ALU_OR;
                    OP_LUI:  ctrl_o.alu_op = ALU_LUI;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            S_IMM_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                ctrl_o.branch_eq = (op_i == OP_BEQ);
                ctrl_o.branch_ne = (op_i == OP_BNE);
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic and
// reset forcing around the combinational decoder.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcodes trap into HALT
// and raise illegal_op; otherwise they run as a 2-cycle NOP).
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       BranchEQ,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    state_t dec_state_s;
    ctrl_t  ctrl_s;

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; wait states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE:               state_d = S_EXECUTE;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMM_EXEC;
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                state_d = S_HALT;
`else
                    default:                state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                if (OP == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Sticky flag set when DECODE sees an opcode it cannot execute.
    always_comb begin
        if ((state_q == S_DECODE) && !is_known_op(OP)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal-opcode flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q & ~reset;
`else
    assign illegal_op = 1'b0;
`endif

    // While reset is held, selects show FETCH values regardless of state_q.
    assign dec_state_s = reset ? S_FETCH : state_q;

    multicycle_ctrl_decode u_decode (
        .state_i     (dec_state_s),
        .op_i        (OP),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_s)
    );

    // Write enables are suppressed during reset so an aborted access writes nothing.
    assign PCWrite  = ctrl_s.pc_write  & ~reset;
    assign BranchEQ = ctrl_s.branch_eq & ~reset;
    assign BranchNE = ctrl_s.branch_ne & ~reset;
    assign MemRead  = ctrl_s.mem_read  & ~reset;
    assign MemWrite = ctrl_s.mem_write & ~reset;
    assign IRWrite  = ctrl_s.ir_write  & ~reset;
    assign RegWrite = ctrl_s.reg_write & ~reset;
    assign IorD     = ctrl_s.iord;
    assign RegDst   = ctrl_s.reg_dst;
    assign MemtoReg = ctrl_s.mem_to_reg;
    assign ALUSrcA  = ctrl_s.alu_src_a;
    assign ALUSrcB  = ctrl_s.alu_src_b;
    assign PCSource = ctrl_s.pc_source;
    assign ALUOp    = ctrl_s.alu_op;
    assign state    = state_q;

endmodule
